// File: rtl/mc_ctrl_if.sv
// Control bus between the multicycle controller and its datapath/memory port.
// The controller takes the master side; the datapath takes the slave side.
interface mc_ctrl_if;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        pcen;
  logic        iord;
  logic        memwrite;
  logic        irwrite;
  logic        regdst;
  logic        memtoreg;
  logic        regwrite;
  logic        alusrca;
  logic [1:0]  alusrcb;
  logic        zext;
  logic [1:0]  pcsrc;
  logic [5:0]  aluop;
  logic        illegal;
  logic [3:0]  state;

  modport master (
    input  instr, zero, mem_ready,
    output pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, zext, pcsrc, aluop, illegal, state
  );

  modport slave (
    output instr, zero, mem_ready,
    input  pcen, iord, memwrite, irwrite, regdst, memtoreg, regwrite,
           alusrca, alusrcb, zext, pcsrc, aluop, illegal, state
  );
endinterface

// File: rtl/mc_ctrl.sv
// Multicycle MIPS control unit: a state register sequences fetch, decode,
// execute, memory and writeback over a shared memory port and single ALU.
// Outputs are decoded combinationally from the state register and instr.
module mc_ctrl (
  input  logic       clk,
  input  logic       rst,
  mc_ctrl_if.master  bus
);

  localparam logic [3:0] S_FETCH  = 4'd0;
  localparam logic [3:0] S_DECODE = 4'd1;
  localparam logic [3:0] S_MEMADR = 4'd2;
  localparam logic [3:0] S_MEMRD  = 4'd3;
  localparam logic [3:0] S_MEMWB  = 4'd4;
  localparam logic [3:0] S_MEMWR  = 4'd5;
  localparam logic [3:0] S_RTEXE  = 4'd6;
  localparam logic [3:0] S_IEXE   = 4'd7;
  localparam logic [3:0] S_ALUWB  = 4'd8;
  localparam logic [3:0] S_BRANCH = 4'd9;
  localparam logic [3:0] S_JUMP   = 4'd10;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;

  localparam logic [5:0] ALU_ADD  = 6'b000000;
  localparam logic [5:0] ALU_SUB  = 6'b000001;
  localparam logic [5:0] ALU_OR   = 6'b000100;
  localparam logic [5:0] ALU_NOR  = 6'b000101;
  localparam logic [5:0] ALU_XOR  = 6'b000110;
  localparam logic [5:0] ALU_LUI  = 6'b001010;
  localparam logic [5:0] ALU_AND  = 6'b010001;

  // R-type function code to ALU code; unsupported codes fall back to add
  function automatic logic [5:0] rt_aluop(input logic [5:0] funct);
    logic [5:0] code;
    case (funct)
      FN_AND:  code = ALU_AND;
      FN_OR:   code = ALU_OR;
      FN_XOR:  code = ALU_XOR;
      FN_NOR:  code = ALU_NOR;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Immediate opcode to ALU code
  function automatic logic [5:0] i_aluop(input logic [5:0] op);
    logic [5:0] code;
    case (op)
      OP_ANDI: code = ALU_AND;
      OP_ORI:  code = ALU_OR;
      OP_XORI: code = ALU_XOR;
      OP_LUI:  code = ALU_LUI;
      default: code = ALU_ADD;
    endcase
    return code;
  endfunction

  // Logical immediates zero-extend; addi and lui sign-extend
  function automatic logic i_zext(input logic [5:0] op);
    logic z;
    case (op)
      OP_ANDI, OP_ORI, OP_XORI: z = 1'b1;
      default:                  z = 1'b0;
    endcase
    return z;
  endfunction

  // Decode-stage dispatch target; FETCH marks an unsupported instruction
  function automatic logic [3:0] dispatch(input logic [5:0] op, input logic [5:0] funct);
    logic [3:0] tgt;
    case (op)
      OP_LW, OP_SW: tgt = S_MEMADR;
      OP_RTYPE: begin
        case (funct)
          FN_AND, FN_OR, FN_XOR, FN_NOR: tgt = S_RTEXE;
          default:                       tgt = S_FETCH;
        endcase
      end
      OP_BEQ:                                    tgt = S_BRANCH;
      OP_ADDI, OP_ANDI, OP_ORI, OP_XORI, OP_LUI: tgt = S_IEXE;
      OP_J:                                      tgt = S_JUMP;
      default:                                   tgt = S_FETCH;
    endcase
    return tgt;
  endfunction

  logic [3:0] state_r;
  logic [3:0] state_nxt_s;
  logic [5:0] op_s;
  logic [5:0] funct_s;
  logic [3:0] dispatch_s;
  logic       unused_instr_s;

  logic       pcwrite_s;
  logic       branch_s;
  logic       iord_s;
  logic       memwrite_s;
  logic       irwrite_s;
  logic       regdst_s;
  logic       memtoreg_s;
  logic       regwrite_s;
  logic       alusrca_s;
  logic [1:0] alusrcb_s;
  logic       zext_s;
  logic [1:0] pcsrc_s;
  logic [5:0] aluop_s;
  logic       illegal_s;

  assign op_s           = bus.instr[31:26];
  assign funct_s        = bus.instr[5:0];
  assign unused_instr_s = ^bus.instr[25:6];
  assign dispatch_s     = dispatch(op_s, funct_s);

  // Next-state selection, including memory-ready stalls
  always_comb begin
    state_nxt_s = S_FETCH;
    case (state_r)
      S_FETCH: begin
        if (bus.mem_ready) state_nxt_s = S_DECODE;
        else               state_nxt_s = S_FETCH;
      end
      S_DECODE: state_nxt_s = dispatch_s;
      S_MEMADR: begin
        if (op_s == OP_SW) state_nxt_s = S_MEMWR;
        else               state_nxt_s = S_MEMRD;
      end
      S_MEMRD: begin
        if (bus.mem_ready) state_nxt_s = S_MEMWB;
        else               state_nxt_s = S_MEMRD;
      end
      S_MEMWB: state_nxt_s = S_FETCH;
      S_MEMWR: begin
        if (bus.mem_ready) state_nxt_s = S_FETCH;
        else               state_nxt_s = S_MEMWR;
      end
      S_RTEXE:  state_nxt_s = S_ALUWB;
      S_IEXE:   state_nxt_s = S_ALUWB;
      S_ALUWB:  state_nxt_s = S_FETCH;
      S_BRANCH: state_nxt_s = S_FETCH;
      S_JUMP:   state_nxt_s = S_FETCH;
      default:  state_nxt_s = S_FETCH;
    endcase
  end

  // State register with synchronous reset back to FETCH
  always_ff @(posedge clk) begin
    if (rst) state_r <= S_FETCH;
    else     state_r <= state_nxt_s;
  end

  // Per-state datapath enables and selects
  always_comb begin
    pcwrite_s  = 1'b0;
    branch_s   = 1'b0;
    iord_s     = 1'b0;
    memwrite_s = 1'b0;
    irwrite_s  = 1'b0;
    regdst_s   = 1'b0;
    memtoreg_s = 1'b0;
    regwrite_s = 1'b0;
    alusrca_s  = 1'b0;
    alusrcb_s  = 2'b00;
    zext_s     = 1'b0;
    pcsrc_s    = 2'b00;
    aluop_s    = ALU_ADD;
    illegal_s  = 1'b0;
    case (state_r)
      S_FETCH: begin
        alusrcb_s = 2'b01;
        irwrite_s = bus.mem_ready;
        pcwrite_s = bus.mem_ready;
      end
      S_DECODE: begin
        alusrcb_s = 2'b11;
        illegal_s = (dispatch_s == S_FETCH);
      end
      S_MEMADR: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
      end
      S_MEMRD: iord_s = 1'b1;
      S_MEMWB: begin
        memtoreg_s = 1'b1;
        regwrite_s = 1'b1;
      end
      S_MEMWR: begin
        iord_s     = 1'b1;
        memwrite_s = 1'b1;
      end
      S_RTEXE: begin
        alusrca_s = 1'b1;
        aluop_s   = rt_aluop(funct_s);
      end
      S_IEXE: begin
        alusrca_s = 1'b1;
        alusrcb_s = 2'b10;
        aluop_s   = i_aluop(op_s);
        zext_s    = i_zext(op_s);
      end
      S_ALUWB: begin
        regdst_s   = (op_s == OP_RTYPE);
        regwrite_s = 1'b1;
      end
      S_BRANCH: begin
        alusrca_s = 1'b1;
        aluop_s   = ALU_SUB;
        pcsrc_s   = 2'b01;
        branch_s  = 1'b1;
      end
      S_JUMP: begin
        pcsrc_s   = 2'b10;
        pcwrite_s = 1'b1;
      end
      default: begin
        aluop_s = ALU_ADD;
      end
    endcase
  end

  // Reset suppresses every write enable so an abandoned instruction leaves no trace
  assign bus.pcen     = ~rst & (pcwrite_s | (branch_s & bus.zero));
  assign bus.memwrite = ~rst & memwrite_s;
  assign bus.irwrite  = ~rst & irwrite_s;
  assign bus.regwrite = ~rst & regwrite_s;
  assign bus.illegal  = ~rst & illegal_s;
  assign bus.iord     = iord_s;
  assign bus.regdst   = regdst_s;
  assign bus.memtoreg = memtoreg_s;
  assign bus.alusrca  = alusrca_s;
  assign bus.alusrcb  = alusrcb_s;
  assign bus.zext     = zext_s;
  assign bus.pcsrc    = pcsrc_s;
  assign bus.aluop    = aluop_s;
  assign bus.state    = state_r;

endmodule

// File: doc/mc_ctrl.md
# mc_ctrl

Multicycle control unit for the MIPS core. It sequences a shared-memory, single-ALU datapath one instruction at a time. Each instruction is broken into fetch, decode, execute, memory and writeback steps. Per-cycle enables and selects are driven from a state register. Instruction and data accesses share one memory port, with a ready handshake that stalls the sequence. It supports the same instruction set and 6-bit ALU control codes as the pipelined core's decoder.

## Interface
Parameters:
- none; opcodes and ALU codes are fixed constants.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- instr  in  32  instruction register contents; stable from DECODE until the next FETCH completes
- zero  in  1  ALU zero flag, used in BRANCH
- mem_ready  in  1  memory port completes the current access this cycle
- pcen  out  1  PC load enable; pcen = pcwrite | (branch & zero)
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memwrite  out  1  memory write strobe
- irwrite  out  1  instruction register load
- regdst  out  1  destination select: 1 = rd, 0 = rt
- memtoreg  out  1  writeback source: 1 = MDR, 0 = ALUOut
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = rs
- alusrcb  out  2  ALU B select: 00 = rt, 01 = const 4, 10 = ext imm, 11 = sext imm<<2
- zext  out  1  imm extension: 1 = zero-extend (andi/ori/xori), 0 = sign-extend
- pcsrc  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target
- aluop  out  6  ALU code: add 000000, sub 000001, or 000100, nor 000101, xor 000110, lui 001010, and 010001
- illegal  out  1  one-cycle pulse on an unsupported op/funct
- state  out  4  current state, for debug

## Operation
Any output not listed for a state is 0. aluop is add by default.

State encodings and actions:
- FETCH(0)
  - Actions: iord=0, alusrca=0, alusrcb=01.
  - When mem_ready: irwrite=1, pcwrite=1, then go to DECODE.
  - Otherwise hold FETCH with no writes.
- DECODE(1)
  - Actions: alusrca=0, alusrcb=11 (branch target into ALUOut).
  - Dispatch on instr[31:26]:
    - 100011 (LW) or 101011 (SW) -> MEMADR
    - 000000 with funct 100100 (and), 100101 (or), 100110 (xor), 100111 (nor) -> RTEXE
    - 000100 (BEQ) -> BRANCH
    - 001000 (ADDI), 001100 (ANDI), 001101 (ORI), 001110 (XORI), 001111 (LUI) -> IEXE
    - 000010 (J) -> JUMP
    - anything else -> illegal=1, go to FETCH
- MEMADR(2)
  - Actions: alusrca=1, alusrcb=10, zext=0.
  - Next: MEMRD for LW, MEMWR for SW.
- MEMRD(3)
  - Actions: iord=1.
  - Hold until mem_ready, then go to MEMWB.
- MEMWB(4)
  - Actions: regdst=0, memtoreg=1, regwrite=1.
  - Next: FETCH.
- MEMWR(5)
  - Actions: iord=1, memwrite=1, held asserted until the cycle mem_ready=1.
  - Next: FETCH.
- RTEXE(6)
  - Actions: alusrca=1, alusrcb=00, aluop from funct (and 010001, or 000100, xor 000110, nor 000101).
  - Next: ALUWB.
- IEXE(7)
  - Actions: alusrca=1, alusrcb=10.
  - ADDI: aluop add, zext=0. ANDI: and, zext=1. ORI: or, zext=1. XORI: xor, zext=1. LUI: lui, zext=0.
  - Next: ALUWB.
- ALUWB(8)
  - Actions: regdst=(instr[31:26]==0), memtoreg=0, regwrite=1.
  - Next: FETCH.
- BRANCH(9)
  - Actions: alusrca=1, alusrcb=00, aluop sub, pcsrc=01, branch=1. pcen=zero.
  - Next: FETCH.
- JUMP(10)
  - Actions: pcsrc=10, pcwrite=1.
  - Next: FETCH.
- Unused encodings 11-15 go to FETCH next cycle, with all enables 0.

## Timing
- Outputs are combinational from the state register and instr; there are no output registers.
- Reset:
  - rst sampled high forces state=FETCH on the next edge.
  - While rst=1, all enables (pcen, memwrite, irwrite, regwrite, illegal) are forced 0, regardless of state.
  - Reset mid-instruction abandons it; no partial write completes after the reset edge.
- Cycle counts with mem_ready tied high:
  - LW 5, SW 4, R-type 4, I-type 4, BEQ 3, J 3, illegal 2.
- Each cycle mem_ready=0 in FETCH, MEMRD or MEMWR adds one cycle. The controller stays in that state with its outputs steady.
- The memory handshake completes only on a cycle where the strobe/state and mem_ready are both high.
- illegal pulses exactly one cycle, in DECODE.

## Test plan
- Reset: drive rst=1 for 2 cycles from state MEMWR -> state=0, memwrite=0, pcen=0, regwrite=0. First FETCH follows rst release.
- LW (0x8C410004) with mem_ready=1 -> states 0,1,2,3,4,0. regwrite=1 only in state 4, with memtoreg=1, regdst=0.
- LW with mem_ready low for 3 cycles in MEMRD -> MEMRD held 4 cycles, iord=1 throughout, total 8 cycles.
- ORI (0x34220F0F) -> IEXE has aluop=000100, zext=1; ALUWB has regdst=0, regwrite=1.
- R-type nor (funct 100111) -> RTEXE aluop=000101; ALUWB regdst=1.
- BEQ with zero=1 -> pcen=1, pcsrc=01 in state 9. With zero=0 -> pcen=0.
- J -> pcsrc=10, pcen=1 in state 10.
- Opcode 111111 -> illegal=1 for one cycle in DECODE, then FETCH, with no writes.
